dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Handshaked data-memory responder: the slave end of the CPU data-memory port.
- Accepts one read or write request at a time, inserts a configurable number of wait states, then returns a one-cycle acknowledge with registered read data.
- Supports per-byte write enables, so the datapath can issue store-byte writes without doing its own read-modify-write.
- Sits between the multi-cycle datapath (ALUOut address, B write data) and the data register DR.

Parameters:
ADDR_W, 10, byte-address width; word index = addr[ADDR_W-1:2]
LATENCY, 2, wait cycles inserted between request acceptance and commit/ack (0..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  1  request valid; sampled only in IDLE
we  input  1  1 = write, 0 = read; captured with req
addr  input  ADDR_W  byte address; addr[1:0] ignored (word-aligned access)
wdata  input  32  write data; byte lane i = wdata[8i+7:8i]
be  input  4  byte enables for writes; ignored for reads
rdata  output  32  read data, registered; valid while ack=1, held until next read ack
ack  output  1  one-cycle completion pulse
busy  output  1  high whenever state != IDLE
err  output  1  one-cycle pulse coincident with ack for a write with be=4'b0000

Behaviour:
- Storage: 2^(ADDR_W-2) x 32-bit register array (256 words at default).
- Reset (synchronous; takes effect on any edge with reset=1, in any state):
  - all memory words cleared to 0; state = IDLE; counter = 0
  - rdata = 0, ack = 0, err = 0, busy = 0
  - an in-flight request is aborted: no write is committed and no ack is issued.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with req=1: capture we, word index, wdata and be into request registers; counter = LATENCY.
  - Next state is WAIT if LATENCY>0, otherwise RESP.
  - req=0: stay in IDLE.
- WAIT:
  - Decrement counter each cycle; when counter reaches 1, next state = RESP.
  - The req input and the request inputs are ignored; captured values are used.
- Commit, on the edge entering RESP:
  - Write with be!=0: update only the bytes whose be[i]=1; other bytes keep their old values.
  - Write with be=0: memory unchanged; err=1 during RESP.
  - Read: rdata <= full 32-bit word at the captured index.
  - No sign or zero extension is applied; the requestor extracts and extends bytes.
- RESP:
  - ack=1 for exactly this cycle; err as above.
  - Next state is always IDLE, and req is not sampled in RESP.
  - Requests are therefore never accepted on consecutive cycles.
- Timing:
  - Request accepted at edge T; ack is high during cycle T+LATENCY+1.
  - Throughput: one access per LATENCY+2 cycles.
- rdata holds its value through writes and idle cycles until the next read commits.
- ack and err are 0 in IDLE and WAIT.
- The requestor must deassert or reassert req after ack; a req held high starts a new access on the first IDLE cycle after RESP.
- Read after write to the same word returns the updated value; the write commits before any later request is accepted.
- Counter width: 4 bits.
- LATENCY outside 0..15 is unsupported (elaboration-time check).

Test Plan:
- Reset, then read addr 0x010 with LATENCY=2 -> busy high 3 cycles; ack high exactly at T+3; rdata=0x00000000; err=0.
- Write 0xDEADBEEF to addr 0x020 with be=4'b1111, then read 0x020 -> read ack returns rdata=0xDEADBEEF; write ack has err=0.
- Write 0x000000AA to 0x020 with be=4'b0001 over 0xDEADBEEF -> subsequent read = 0xDEADBEAA. Then write 0x55000000 with be=4'b1000 -> read = 0x55ADBEAA.
- Write with be=4'b0000 to 0x020 -> ack and err both high in the same single cycle; subsequent read unchanged (0x55ADBEAA).
- Hold req=1 continuously with LATENCY=0 -> ack every 2nd cycle, never on consecutive cycles. Toggle addr during WAIT with LATENCY=3 -> captured address used.
- Assert reset during WAIT of a write of 0x12345678 to 0x040 -> no ack; busy=0 next cycle; read of 0x040 returns 0x00000000.

Source files
------------

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_responder
// Function : Data-memory slave with programmable wait states, byte-enabled
//            writes and a registered read-data port.
// Revision : 1.0 - initial release
// ============================================================================
module dm_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              busy,
    output logic              err
);
    localparam int         IDX_W   = ADDR_W - 2;
    localparam int         DEPTH   = 1 << IDX_W;
    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic             req_we;
    logic [IDX_W-1:0] req_idx;
    logic [31:0]      req_wdata;
    logic [3:0]       req_be;
    logic             acc_we;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_be;
    logic             commit;
    logic             unused_addr_bits;
    logic [31:0]      mem [DEPTH];

    generate
        if (LATENCY < 0 || LATENCY > 15) begin : g_latency_check
            $error("dm_responder: LATENCY must be in 0..15");
        end
    endgenerate

    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt   = LAT_CNT;
                    state_nxt = (LAT_CNT != 4'd0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the commit happens on the accept edge itself,
    // before the request registers hold anything, so take the live inputs.
    assign acc_we    = (state == IDLE) ? we                : req_we;
    assign acc_idx   = (state == IDLE) ? addr[ADDR_W-1:2]  : req_idx;
    assign acc_wdata = (state == IDLE) ? wdata             : req_wdata;
    assign acc_be    = (state == IDLE) ? be                : req_be;
    assign commit    = (state_nxt == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_we    <= 1'b0;
            req_idx   <= '0;
            req_wdata <= 32'd0;
            req_be    <= 4'd0;
            rdata     <= 32'd0;
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= 32'd0;
            end
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                req_we    <= we;
                req_idx   <= addr[ADDR_W-1:2];
                req_wdata <= wdata;
                req_be    <= be;
            end
            if (commit) begin
                if (acc_we) begin
                    for (int i = 0; i < 4; i++) begin
                        if (acc_be[i]) begin
                            mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                        end
                    end
                end else begin
                    rdata <= mem[acc_idx];
                end
            end
        end
    end

    assign ack  = (state == RESP);
    assign busy = (state != IDLE);
    assign err  = (state == RESP) && req_we && (req_be == 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_responder
// Function : Self-checking bench driving three responders (LATENCY 2, 0, 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_responder;
    localparam int NDUT = 3;
    localparam int LATS [NDUT] = '{2, 0, 3};

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req   [NDUT];
    logic        we    [NDUT];
    logic [9:0]  addr  [NDUT];
    logic [31:0] wdata [NDUT];
    logic [3:0]  be    [NDUT];
    logic [31:0] rdata [NDUT];
    logic        ack   [NDUT];
    logic        busy  [NDUT];
    logic        err   [NDUT];

    exp_t        sb [$];
    exp_t        mon_e;
    logic [31:0] last_rd  [NDUT];
    logic        prev_ack [NDUT];
    vec_t        vecs [13];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            dm_responder #(.ADDR_W(10), .LATENCY(LATS[g])) u_dut (
                .clk   (clk),
                .reset (reset),
                .req   (req[g]),
                .we    (we[g]),
                .addr  (addr[g]),
                .wdata (wdata[g]),
                .be    (be[g]),
                .rdata (rdata[g]),
                .ack   (ack[g]),
                .busy  (busy[g]),
                .err   (err[g])
            );
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every ack must match the oldest outstanding request.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (reset) begin
                last_rd[k] = 32'd0;
            end
            if (ack[k]) begin
                if (sb.size() == 0) begin
                    check($sformatf("unexpected_ack_dut%0d", k), 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_dut_id", 32'(k), 32'(mon_e.id));
                    check("err", {31'd0, err[k]}, {31'd0, mon_e.err});
                    if (!mon_e.we) begin
                        check("rdata", rdata[k], mon_e.rdata);
                        last_rd[k] = mon_e.rdata;
                    end else begin
                        check("rdata_hold", rdata[k], last_rd[k]);
                    end
                end
                if (prev_ack[k]) begin
                    check("ack_back_to_back", 32'd1, 32'd0);
                end
            end else if (err[k]) begin
                check("err_without_ack", 32'd1, 32'd0);
            end
            prev_ack[k] = ack[k];
        end
    end

    task automatic access(input int k, input logic w, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic [31:0] er, input logic ee);
        int cyc;
        int bsy;
        sb.push_back('{k, w, er, ee});
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
        @(posedge clk);
        #1;
        req[k] = 1'b0; we[k] = ~w; be[k] = ~b;
        cyc = 0;
        bsy = 0;
        do begin
            addr[k]  = 10'($urandom);
            wdata[k] = $urandom;
            @(negedge clk);
            cyc++;
            bsy += int'(busy[k]);
        end while (!ack[k] && cyc < 20);
        check("ack_latency", 32'(cyc), 32'(LATS[k] + 1));
        check("busy_cycles", 32'(bsy), 32'(LATS[k] + 1));
        @(negedge clk);
        check("busy_after_ack", {31'd0, busy[k]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; be[k] = '0;
            last_rd[k] = 32'd0; prev_ack[k] = 1'b0;
        end
        vecs[0]  = '{1'b0, 10'h010, 32'h0,        4'h0, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 10'h020, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 10'h020, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 10'h020, 32'h000000AA, 4'h1, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 10'h020, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        vecs[5]  = '{1'b1, 10'h020, 32'h55000000, 4'h8, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 10'h020, 32'h0,        4'h0, 32'h55ADBEAA, 1'b0};
        vecs[7]  = '{1'b1, 10'h020, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 10'h020, 32'h0,        4'h0, 32'h55ADBEAA, 1'b0};
        vecs[9]  = '{1'b1, 10'h024, 32'h11223344, 4'h6, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 10'h027, 32'h0,        4'h0, 32'h00223300, 1'b0};
        vecs[11] = '{1'b0, 10'h021, 32'h0,        4'h0, 32'h55ADBEAA, 1'b0};
        vecs[12] = '{1'b0, 10'h3FC, 32'h0,        4'h0, 32'h00000000, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_rdata", rdata[0], 32'd0);
        check("reset_ack",   {31'd0, ack[0]},  32'd0);
        check("reset_busy",  {31'd0, busy[0]}, 32'd0);
        check("reset_err",   {31'd0, err[0]},  32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            access(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].rdata, vecs[i].err);
        end

        // LATENCY=0 with req held high: accepts on every other edge.
        for (int i = 0; i < 4; i++) sb.push_back('{1, 1'b0, 32'd0, 1'b0});
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'h008; be[1] = 4'h0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            if (c == 6) begin
                #1 req[1] = 1'b0;
            end
            @(negedge clk);
            check("held_req_ack_pattern", {31'd0, ack[1]}, (c % 2 == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("held_req_idle", {31'd0, busy[1]}, 32'd0);
        access(1, 1'b1, 10'h008, 32'h0A0B0C0D, 4'hF, 32'h0, 1'b0);
        access(1, 1'b0, 10'h008, 32'h0, 4'h0, 32'h0A0B0C0D, 1'b0);

        // LATENCY=3: address/data scrambled every WAIT cycle inside access().
        access(2, 1'b1, 10'h100, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        access(2, 1'b0, 10'h100, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

        // Reset during WAIT aborts the write.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 10'h040; wdata[0] = 32'h12345678; be[0] = 4'hF;
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        check("busy_in_wait", {31'd0, busy[0]}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy[0]}, 32'd0);
        check("abort_ack",  {31'd0, ack[0]},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        access(0, 1'b0, 10'h040, 32'h0, 4'h0, 32'h00000000, 1'b0);
        access(0, 1'b0, 10'h020, 32'h0, 4'h0, 32'h00000000, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
